// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller
//
// Purpose:
//   Multi-cycle sequencer for an RV32 datapath supporting add, sub, addi, lw,
//   sw, beq and jal. It walks each instruction through FETCH, DECODE,
//   EXECUTE, MEM and WB. A single memory port is shared between instruction
//   fetch (address = PC) and data access (address = ALU result). The block
//   also counts retired instructions.
//
//   Outputs are decoded combinationally from the current state and the
//   opcode/funct/zero inputs. Only the state, the fetch-pending flag, the
//   retired-instruction counter and the sticky illegal flag are registered.
//
// Optional feature:
//   MC_ILLEGAL_TRAP_EN
//     Defined:   unsupported opcodes and unsupported R-type funct7/funct3
//                combinations move DECODE -> HALT, set the sticky illegal_o
//                flag and are not counted. Only reset leaves HALT.
//     Undefined: HALT is unreachable and illegal_o is absent. Unsupported
//                opcodes retire as NOPs, and unsupported R-type combinations
//                write back with alu_control_o = 4'b0000.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   en_i           in   1   run enable, sampled only when FETCH would issue
//   opcode_i       in   7   IR[6:0], valid from DECODE onward
//   funct3_i       in   3   IR[14:12]
//   funct7_i       in   7   IR[31:25]
//   zero_i         in   1   ALU zero flag, used in EXECUTE for beq
//   mem_ready_i    in   1   memory accepts/completes the request this cycle
//   mem_req_o      out  1   memory request
//   mem_we_o       out  1   memory write (sw only)
//   mem_sel_o      out  1   address select: 0 = PC, 1 = ALU result
//   ir_write_o     out  1   latch IR and old PC
//   pc_write_o     out  1   PC update strobe
//   pc_src_o       out  2   00 = PC+4, 01 = branch target, 10 = jal target
//   reg_write_o    out  1   register-file write strobe
//   wb_sel_o       out  2   00 = ALU, 01 = memory data, 10 = link (old PC+4)
//   alu_src_o      out  1   ALU operand B: 0 = rs2, 1 = immediate
//   alu_control_o  out  4   ALU operation
//   state_o        out  3   FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WB=4 HALT=5
//   instret_o      out  32  retired-instruction count (wraps)
//   illegal_o      out  1   sticky illegal flag (MC_ILLEGAL_TRAP_EN only)
//
// Memory handshake (valid/ready):
//   mem_req_o is the valid. A transfer completes in a cycle where mem_req_o
//   and mem_ready_i are both high. Once mem_req_o rises it stays high, with
//   mem_sel_o and mem_we_o stable, until that completing cycle. Dropping
//   en_i does not withdraw an issued fetch. mem_ready_i is ignored while
//   mem_req_o is low. Reset drops any request immediately.
// ============================================================================
module multicycle_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_sel_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic        reg_write_o,
    output logic [1:0]  wb_sel_o,
    output logic        alu_src_o,
    output logic [3:0]  alu_control_o,
    output logic [2:0]  state_o,
    output logic [31:0] instret_o
`ifdef MC_ILLEGAL_TRAP_EN
  , output logic        illegal_o
`endif
);

    localparam logic [3:0] ALU_OP_ADD = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB = 4'b0110;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ADDI  = 7'b0010011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JAL    = 2'b10;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_RTYPE,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_JAL
    } cls_e;

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;
    logic        fetch_req;
    logic        trap;
    cls_e        cls;
    logic        r_add, r_sub;
    logic [3:0]  r_alu;

    // ------------------------------------------------------------------
    // Instruction classification. The IR is held stable from DECODE until
    // the next fetch, so the class is re-derived every cycle instead of
    // being latched.
    // ------------------------------------------------------------------
    always_comb begin
        r_add = (funct7_i == 7'b0000000) && (funct3_i == 3'b000);
        r_sub = (funct7_i == 7'b0100000) && (funct3_i == 3'b000);
        if (r_add) begin
            r_alu = ALU_OP_ADD;
        end else if (r_sub) begin
            r_alu = ALU_OP_SUB;
        end else begin
            r_alu = 4'b0000;
        end

        case (opcode_i)
            OPC_RTYPE: cls = CLS_RTYPE;
            OPC_ADDI:  cls = CLS_ADDI;
            OPC_LW:    cls = CLS_LW;
            OPC_SW:    cls = CLS_SW;
            OPC_BEQ:   cls = CLS_BEQ;
            OPC_JAL:   cls = CLS_JAL;
            default:   cls = CLS_NONE;
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign trap      = (cls == CLS_NONE) || ((cls == CLS_RTYPE) && !(r_add || r_sub));
    assign illegal_d = illegal_q | ((state_q == S_DECODE) & trap);
    assign illegal_o = illegal_q;
`else
    assign trap = 1'b0;
`endif

    // A fetch request is issued when enabled, and kept alive by the pending
    // flag if en_i drops before memory answers.
    assign fetch_req = en_i | pending_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (fetch_req) begin
                    if (mem_ready_i) begin
                        state_d   = S_DECODE;
                        pending_d = 1'b0;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
            end

            S_DECODE: begin
                if (trap) begin
                    state_d = S_HALT;
                end else if (cls == CLS_NONE) begin
                    // Unsupported opcode without trapping: retire as a NOP.
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                case (cls)
                    CLS_RTYPE, CLS_ADDI: state_d = S_WB;
                    CLS_LW, CLS_SW:      state_d = S_MEM;
                    default: begin
                        // beq and jal finish here.
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                if (mem_ready_i) begin
                    if (cls == CLS_SW) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign instret_d = retire ? (instret_q + 32'd1) : instret_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pending_q <= 1'b0;
            instret_q <= 32'd0;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            instret_q <= instret_d;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign state_o   = state_q;
    assign instret_o = instret_q;

    // ------------------------------------------------------------------
    // Output decode. Everything is forced low while reset is asserted so a
    // request in flight is dropped at once, even with en_i high.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_sel_o     = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        pc_src_o      = PC_SRC_PLUS4;
        reg_write_o   = 1'b0;
        wb_sel_o      = WB_SEL_ALU;
        alu_src_o     = 1'b0;
        alu_control_o = 4'b0000;

        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req_o = fetch_req;
                    if (fetch_req && mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                        pc_src_o   = PC_SRC_PLUS4;
                    end
                end

                S_EXECUTE: begin
                    case (cls)
                        CLS_RTYPE: begin
                            alu_control_o = r_alu;
                        end
                        CLS_ADDI, CLS_LW, CLS_SW: begin
                            alu_src_o     = 1'b1;
                            alu_control_o = ALU_OP_ADD;
                        end
                        CLS_BEQ: begin
                            alu_control_o = ALU_OP_SUB;
                            if (zero_i) begin
                                pc_write_o = 1'b1;
                                pc_src_o   = PC_SRC_BRANCH;
                            end
                        end
                        CLS_JAL: begin
                            reg_write_o = 1'b1;
                            wb_sel_o    = WB_SEL_LINK;
                            pc_write_o  = 1'b1;
                            pc_src_o    = PC_SRC_JAL;
                        end
                        default: begin
                        end
                    endcase
                end

                S_MEM: begin
                    // Address computation stays on the ALU for the whole access.
                    mem_req_o     = 1'b1;
                    mem_sel_o     = 1'b1;
                    mem_we_o      = (cls == CLS_SW);
                    alu_src_o     = 1'b1;
                    alu_control_o = ALU_OP_ADD;
                end

                S_WB: begin
                    reg_write_o = 1'b1;
                    wb_sel_o    = (cls == CLS_LW) ? WB_SEL_MEM : WB_SEL_ALU;
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Each instruction is described by
// its opcode/funct, the zero flag and the number of memory wait cycles. From
// that description the bench expands the cycle-by-cycle output vector the
// instruction must produce and queues it. A single negedge process compares
// every queued vector with the DUT. Literal checks pin reset behaviour,
// cycles per instruction and the retired-instruction count.
// ============================================================================
module tb_multicycle_controller;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;

    localparam logic [2:0] ST_F = 3'd0;
    localparam logic [2:0] ST_D = 3'd1;
    localparam logic [2:0] ST_E = 3'd2;
    localparam logic [2:0] ST_M = 3'd3;
    localparam logic [2:0] ST_W = 3'd4;
    localparam logic [2:0] ST_H = 3'd5;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst_n;
    logic        en;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero;
    logic        mem_ready;
    logic        mem_req_o;
    logic        mem_we_o;
    logic        mem_sel_o;
    logic        ir_write_o;
    logic        pc_write_o;
    logic [1:0]  pc_src_o;
    logic        reg_write_o;
    logic [1:0]  wb_sel_o;
    logic        alu_src_o;
    logic [3:0]  alu_control_o;
    logic [2:0]  state_o;
    logic [31:0] instret_o;
`ifdef MC_ILLEGAL_TRAP_EN
    logic        illegal_o;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en),
        .opcode_i      (opcode),
        .funct3_i      (funct3),
        .funct7_i      (funct7),
        .zero_i        (zero),
        .mem_ready_i   (mem_ready),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_sel_o     (mem_sel_o),
        .ir_write_o    (ir_write_o),
        .pc_write_o    (pc_write_o),
        .pc_src_o      (pc_src_o),
        .reg_write_o   (reg_write_o),
        .wb_sel_o      (wb_sel_o),
        .alu_src_o     (alu_src_o),
        .alu_control_o (alu_control_o),
        .state_o       (state_o),
        .instret_o     (instret_o)
`ifdef MC_ILLEGAL_TRAP_EN
      , .illegal_o     (illegal_o)
`endif
    );

    // ---------------- scoreboard ----------------
    // Vector layout: state[49:47] req we sel irw pcw pc_src[41:40] rw
    //                wb_sel[38:37] alu_src alu_ctl[35:32] instret[31:0]
    logic [49:0] exp_q[$];
    logic [49:0] cmp_exp;
    logic [49:0] cmp_got;
    logic [31:0] model_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [49:0] mk(input logic [2:0] st, input logic rq, input logic we,
                                       input logic sel, input logic irw, input logic pcw,
                                       input logic [1:0] pcs, input logic rw, input logic [1:0] wbs,
                                       input logic asrc, input logic [3:0] actl,
                                       input logic [31:0] cnt);
        return {st, rq, we, sel, irw, pcw, pcs, rw, wbs, asrc, actl, cnt};
    endfunction

    function automatic logic [49:0] mk_quiet(input logic [2:0] st, input logic [31:0] cnt);
        return mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, cnt);
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_exp = exp_q.pop_front();
            cmp_got = {state_o, mem_req_o, mem_we_o, mem_sel_o, ir_write_o, pc_write_o,
                       pc_src_o, reg_write_o, wb_sel_o, alu_src_o, alu_control_o, instret_o};
            n_vec++;
            if (cmp_got !== cmp_exp) begin
                n_err++;
                $display("FAIL cycle_vec @%0t: got st=%0d ctl=%h instret=%h, expected st=%0d ctl=%h instret=%h",
                         $time, cmp_got[49:47], cmp_got[46:32], cmp_got[31:0],
                         cmp_exp[49:47], cmp_exp[46:32], cmp_exp[31:0]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic e, input logic rdy, input logic z, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [49:0] exp);
        @(posedge clk);
        #1;
        en        = e;
        mem_ready = rdy;
        zero      = z;
        opcode    = op;
        funct3    = f3;
        funct7    = f7;
        exp_q.push_back(exp);
    endtask

    // Idle in FETCH with en low; mem_ready is held high to show it is ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, 1'b0, OP_I, 3'b000, 7'd0, mk_quiet(ST_F, model_cnt));
        end
    endtask

    // Expands one instruction into its expected cycles.
    // fw: fetch wait cycles, mw: MEM wait cycles, en_wait: en during fetch waits.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input int fw, input int mw, input logic en_wait,
                             output int ncyc);
        logic [31:0] c;
        logic        legal_op;
        logic        r_ok;
        logic        trap;
        logic [3:0]  r_alu;
        c        = model_cnt;
        ncyc     = 0;
        legal_op = (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
                   (op == OP_BEQ) || (op == OP_JAL);
        r_ok     = (f3 == 3'b000) && ((f7 == 7'b0000000) || (f7 == 7'b0100000));
        r_alu    = !r_ok ? 4'h0 : ((f7 == 7'b0100000) ? SUB : ADD);
        trap     = TRAP && (!legal_op || ((op == OP_R) && !r_ok));

        for (int i = 0; i < fw; i++) begin
            cycle((i == 0) ? 1'b1 : en_wait, 1'b0, z, op, f3, f7,
                  mk(ST_F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, c));
            ncyc++;
        end
        cycle((fw == 0) ? 1'b1 : en_wait, 1'b1, z, op, f3, f7,
              mk(ST_F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, c));
        cycle(1'b1, 1'b1, z, op, f3, f7, mk_quiet(ST_D, c));
        ncyc += 2;

        if (trap) begin
            for (int i = 0; i < 3; i++) begin
                cycle(1'b1, 1'b1, z, op, f3, f7, mk_quiet(ST_H, c));
            end
            ncyc += 3;
        end else if (!legal_op) begin
            model_cnt = c + 32'd1;
        end else begin
            case (op)
                OP_R: begin
                    cycle(1'b1, 1'b1, z, op, f3, f7,
                          mk(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, r_alu, c));
                    cycle(1'b1, 1'b1, z, op, f3, f7,
                          mk(ST_W, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 4'h0, c));
                    ncyc += 2;
                end
                OP_I: begin
                    cycle(1'b1, 1'b1, z, op, f3, f7,
                          mk(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, ADD, c));
                    cycle(1'b1, 1'b1, z, op, f3, f7,
                          mk(ST_W, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 4'h0, c));
                    ncyc += 2;
                end
                OP_LW, OP_SW: begin
                    cycle(1'b1, 1'b1, z, op, f3, f7,
                          mk(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, ADD, c));
                    ncyc++;
                    for (int i = 0; i <= mw; i++) begin
                        cycle(1'b1, (i == mw), z, op, f3, f7,
                              mk(ST_M, 1'b1, (op == OP_SW), 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00,
                                 1'b1, ADD, c));
                        ncyc++;
                    end
                    if (op == OP_LW) begin
                        cycle(1'b1, 1'b1, z, op, f3, f7,
                              mk(ST_W, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 4'h0, c));
                        ncyc++;
                    end
                end
                OP_BEQ: begin
                    cycle(1'b1, 1'b1, z, op, f3, f7,
                          mk(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, z, z ? 2'b01 : 2'b00, 1'b0, 2'b00,
                             1'b0, SUB, c));
                    ncyc++;
                end
                OP_JAL: begin
                    cycle(1'b1, 1'b1, z, op, f3, f7,
                          mk(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 4'h0, c));
                    ncyc++;
                end
                default: begin
                end
            endcase
            model_cnt = c + 32'd1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nc;
        rst_n     = 1'b0;
        en        = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        opcode    = OP_I;
        funct3    = 3'b000;
        funct7    = 7'd0;
        model_cnt = 32'd0;

        // Reset held with en high: nothing may be requested.
        #3;
        check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_state", {29'd0, state_o}, 32'd0);
        check("rst_instret", instret_o, 32'd0);
        @(posedge clk);
        #1;
        en    = 1'b0;
        rst_n = 1'b1;
        idle(2);

        run_instr(OP_I, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1, nc);
        check("cyc_addi", nc, 32'd4);
        idle(1);
        check("instret_addi", instret_o, 32'd1);

        run_instr(OP_R, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1, nc);
        check("cyc_add", nc, 32'd4);
        run_instr(OP_R, 3'b000, 7'b0100000, 1'b1, 0, 0, 1'b1, nc);
        run_instr(OP_LW, 3'b010, 7'b0000000, 1'b0, 0, 3, 1'b1, nc);
        check("cyc_lw_3wait", nc, 32'd8);
        run_instr(OP_LW, 3'b010, 7'b0000000, 1'b0, 2, 0, 1'b0, nc);
        check("cyc_lw_fetch_pending", nc, 32'd7);
        run_instr(OP_SW, 3'b010, 7'b0000000, 1'b0, 0, 0, 1'b1, nc);
        check("cyc_sw", nc, 32'd4);
        run_instr(OP_BEQ, 3'b000, 7'b0000000, 1'b1, 0, 0, 1'b1, nc);
        check("cyc_beq_taken", nc, 32'd3);
        run_instr(OP_BEQ, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1, nc);
        check("cyc_beq_not_taken", nc, 32'd3);
        run_instr(OP_JAL, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1, nc);
        check("cyc_jal", nc, 32'd3);
        idle(1);
        check("instret_after_nine", instret_o, 32'd9);

`ifndef MC_ILLEGAL_TRAP_EN
        run_instr(OP_R, 3'b000, 7'b0000001, 1'b0, 0, 0, 1'b1, nc);
        run_instr(OP_BAD, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1, nc);
        check("cyc_nop", nc, 32'd2);
        idle(1);
        check("instret_after_nop", instret_o, 32'd11);
`endif

        // Counter wrap: preload all-ones, then retire one instruction.
        @(negedge clk);
        #1;
        force dut.instret_q = 32'hFFFF_FFFF;
        model_cnt = 32'hFFFF_FFFF;
        idle(1);
        @(negedge clk);
        #1;
        release dut.instret_q;
        idle(1);
        run_instr(OP_I, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1, nc);
        idle(1);
        check("instret_wrap", instret_o, 32'd0);
        run_instr(OP_I, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1, nc);

        // sw stalled in MEM, then reset mid-access.
        cycle(1'b1, 1'b1, 1'b0, OP_SW, 3'b010, 7'd0,
              mk(ST_F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, model_cnt));
        cycle(1'b1, 1'b1, 1'b0, OP_SW, 3'b010, 7'd0, mk_quiet(ST_D, model_cnt));
        cycle(1'b1, 1'b1, 1'b0, OP_SW, 3'b010, 7'd0,
              mk(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, ADD, model_cnt));
        cycle(1'b1, 1'b0, 1'b0, OP_SW, 3'b010, 7'd0,
              mk(ST_M, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, ADD, model_cnt));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmem_rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("midmem_rst_state", {29'd0, state_o}, 32'd0);
        check("midmem_rst_instret", instret_o, 32'd0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        model_cnt = 32'd0;
        idle(3);
        run_instr(OP_I, 3'b000, 7'b0000000, 1'b0, 1, 0, 1'b1, nc);
        idle(1);
        check("instret_after_reset", instret_o, 32'd1);

`ifdef MC_ILLEGAL_TRAP_EN
        run_instr(OP_BAD, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1, nc);
        check("illegal_sticky", {31'd0, illegal_o}, 32'd1);
        check("halt_instret", instret_o, 32'd1);
`endif

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
